muldiv_sched: RTL and testbench

- Sequences the multi-cycle multiply/divide resources for the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU per EX instruction and latches its operands.
- Starts either the fixed-latency multiplier or the handshaked iterative divider, then captures the 64-bit {hi,lo} result.
- Generates the EX-stage stall request consumed by the hazard unit and the HI/LO write pulse.

---
 rtl/muldiv_sched_if.sv | 23 ++
 rtl/muldiv_sched.sv | 126 ++++++++++++
 tb/tb_muldiv_sched.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - scheduler-to-unit bus for the multiplier and iterative divider
// master = muldiv_sched, slave = multiply/divide units.
interface muldiv_sched_if;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic        mult_start;
    logic [63:0] mult_result;
    logic        div_start;
    logic        div_ready;
    logic [63:0] div_result;
    logic        div_annul;

    modport master (
        output op_a, op_b, op_signed, mult_start, div_start, div_annul,
        input  mult_result, div_ready, div_result
    );

    modport slave (
        input  op_a, op_b, op_signed, mult_start, div_start, div_annul,
        output mult_result, div_ready, div_result
    );
endinterface

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - EX-stage multiply/divide sequencer with stall and HI/LO write control
// Optional MULDIV_DIVZERO_BYPASS_EN: divide-by-zero completes without using the divider.
module muldiv_sched #(
    parameter int MULT_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_op_valid,
    input  logic                  ex_is_div,
    input  logic                  ex_signed,
    input  logic [31:0]           ex_src_a,
    input  logic [31:0]           ex_src_b,
    input  logic                  ex_flush,
    input  logic                  ex_hold,
    muldiv_sched_if.master        mdu,
    output logic                  mdu_stall,
    output logic                  hilo_we,
    output logic [63:0]           hilo_wdata
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MBUSY = 2'd1;
    localparam logic [1:0] S_DBUSY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] LAT     = 4'(MULT_LAT);

    logic [1:0]  state, state_nxt;
    logic [3:0]  count;
    logic [31:0] op_a_q, op_b_q;
    logic        op_signed_q;
    logic        annul_q;
    logic        accept;
    logic        div_zero;
    logic        stall_c;

    assign accept = (state == S_IDLE) & ex_op_valid & ~ex_flush;

`ifdef MULDIV_DIVZERO_BYPASS_EN
    assign div_zero = ex_is_div & (ex_src_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (div_zero)
                        state_nxt = S_DONE;
                    else if (ex_is_div)
                        state_nxt = S_DBUSY;
                    else
                        state_nxt = S_MBUSY;
                end
            end
            // Flush wins over counter expiry and div_ready in the same cycle.
            S_MBUSY: begin
                if (ex_flush)
                    state_nxt = S_IDLE;
                else if (count == 4'd1)
                    state_nxt = S_DONE;
            end
            S_DBUSY: begin
                if (ex_flush)
                    state_nxt = S_IDLE;
                else if (mdu.div_ready)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ex_flush || !ex_hold)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= 4'd0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            op_signed_q <= 1'b0;
            annul_q     <= 1'b0;
            hilo_wdata  <= 64'd0;
        end else begin
            state   <= state_nxt;
            annul_q <= (state == S_DBUSY) & ex_flush;
            if (accept) begin
                op_a_q      <= ex_src_a;
                op_b_q      <= ex_src_b;
                op_signed_q <= ex_signed;
                count       <= LAT;
                if (div_zero)
                    hilo_wdata <= {ex_src_a, 32'hFFFF_FFFF};
            end
            if (state == S_MBUSY) begin
                count <= count - 4'd1;
                if (!ex_flush && count == 4'd1)
                    hilo_wdata <= mdu.mult_result;
            end
            if (state == S_DBUSY && !ex_flush && mdu.div_ready)
                hilo_wdata <= mdu.div_result;
        end
    end

    always_comb begin
        stall_c = 1'b0;
        case (state)
            S_IDLE:  stall_c = accept;
            S_MBUSY: stall_c = 1'b1;
            S_DBUSY: stall_c = 1'b1;
            default: stall_c = 1'b0;
        endcase
    end

    // Gated by rst so the stall request drops the instant reset is applied.
    assign mdu_stall      = stall_c & ~rst;
    assign hilo_we        = (state == S_DONE) & ~ex_hold & ~ex_flush;
    assign mdu.op_a       = op_a_q;
    assign mdu.op_b       = op_b_q;
    assign mdu.op_signed  = op_signed_q;
    assign mdu.mult_start = (state == S_MBUSY) & (count == LAT);
    assign mdu.div_start  = (state == S_DBUSY) & ~mdu.div_ready;
    assign mdu.div_annul  = annul_q;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - scoreboard bench for muldiv_sched with behavioural mult/div units
module tb_muldiv_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_op_valid, ex_is_div, ex_signed, ex_flush, ex_hold;
    logic [31:0] ex_src_a, ex_src_b;
    logic        mdu_stall, hilo_we;
    logic [63:0] hilo_wdata;

    muldiv_sched_if mu();

    muldiv_sched #(.MULT_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .ex_op_valid(ex_op_valid), .ex_is_div(ex_is_div), .ex_signed(ex_signed),
        .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
        .ex_flush(ex_flush), .ex_hold(ex_hold),
        .mdu(mu),
        .mdu_stall(mdu_stall), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_we = 0;
    int          div_lat = 5;
    bit          force_ready = 0;
    logic [63:0] exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result: MULT -> 64-bit product, DIV -> {remainder, quotient}.
    function automatic logic [63:0] ref_res(bit is_div, bit sgn, logic [31:0] a, logic [31:0] b);
        longint p;
        int sa, sb, q, r;
        logic [31:0] uq, ur;
        if (!is_div) begin
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = longint'({32'd0, a}) * longint'({32'd0, b});
            return 64'(p);
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Scoreboard monitor: every HI/LO write must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!rst && hilo_we) begin
            n_we++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_hilo_we: got wdata %h with no op outstanding", hilo_wdata);
            end else begin
                chk("hilo_wdata", hilo_wdata, exp_q.pop_front());
            end
        end
    end

    // Behavioural units: multiplier result valid the cycle after mult_start,
    // divider answers div_lat cycles after accepting div_start.
    initial begin
        bit ms, ds, an, s, busy;
        int cnt;
        logic [31:0] a, b;
        logic [63:0] dres;
        busy = 0; cnt = 0; dres = '0;
        mu.mult_result = '0; mu.div_ready = 0; mu.div_result = '0;
        forever begin
            @(negedge clk);
            ms = mu.mult_start; ds = mu.div_start & !busy; an = mu.div_annul;
            a = mu.op_a; b = mu.op_b; s = mu.op_signed;
            @(posedge clk); #1;
            mu.mult_result = ms ? ref_res(0, s, a, b) : {$urandom, $urandom};
            mu.div_ready = 0;
            mu.div_result = {$urandom, $urandom};
            if (rst || an) busy = 0;
            else if (ds) begin busy = 1; cnt = div_lat; dres = ref_res(1, s, a, b); end
            if (force_ready) begin
                force_ready = 0;
                mu.div_ready = 1;
            end else if (busy) begin
                if (cnt == 0) begin mu.div_ready = 1; mu.div_result = dres; busy = 0; end
                else cnt--;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle_ex();
        ex_op_valid = 0; ex_flush = 0; ex_hold = 0;
        ex_is_div = 0; ex_signed = 0; ex_src_a = $urandom; ex_src_b = $urandom;
    endtask

    task automatic drive_op(bit d, bit s, logic [31:0] a, logic [31:0] b);
        ex_op_valid = 1; ex_is_div = d; ex_signed = s;
        ex_src_a = a; ex_src_b = b; ex_flush = 0; ex_hold = 0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_stall"}, 64'(mdu_stall), 0);
        chk({tag, "_hilo_we"}, 64'(hilo_we), 0);
        chk({tag, "_hilo_wdata"}, hilo_wdata, 0);
        chk({tag, "_mult_start"}, 64'(mu.mult_start), 0);
        chk({tag, "_div_start"}, 64'(mu.div_start), 0);
        chk({tag, "_div_annul"}, 64'(mu.div_annul), 0);
        chk({tag, "_op_a"}, 64'(mu.op_a), 0);
        chk({tag, "_op_b"}, 64'(mu.op_b), 0);
        chk({tag, "_op_signed"}, 64'(mu.op_signed), 0);
    endtask

    // EX-stage model: the instruction stays in EX until it is flushed or
    // sees mdu_stall=0 with ex_hold=0; operands are scrambled after issue.
    task automatic run_op(bit d, bit s, logic [31:0] a, logic [31:0] b, int flush_at, int hold_pct);
        int c;
        bit done;
        c = 0; done = 0;
        cyc();
        drive_op(d, s, a, b);
        ex_flush = (flush_at == 0);
        if (flush_at != 0) exp_q.push_back(ref_res(d, s, a, b));
        while (!done) begin
            @(negedge clk);
            if (ex_flush || (!mdu_stall && !ex_hold)) done = 1;
            else if (c > 300) begin
                n_chk++; n_fail++;
                $display("FAIL op_timeout: got no completion after %0d cycles expected at most 300", c);
                done = 1;
            end else begin
                cyc();
                c++;
                ex_src_a = $urandom; ex_src_b = $urandom; ex_signed = 1'($urandom);
                ex_hold = ($urandom_range(99) < hold_pct);
                ex_flush = (c == flush_at);
                if (ex_flush && exp_q.size() > 0) void'(exp_q.pop_back());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, we0;
        bit start_ok;
        logic [63:0] e;
        bit d, s;
        logic [31:0] a, b;
        int fa;

        rst = 1;
        idle_ex();
        ex_src_a = 0; ex_src_b = 0;
        repeat (2) cyc();
        @(negedge clk);
        chk_all_zero("reset");
        cyc(); rst = 0;

        // MULT 7*6 timing
        cyc();
        drive_op(0, 0, 32'd7, 32'd6);
        exp_q.push_back(64'd42);
        @(negedge clk); chk("t1_c0_stall", 64'(mdu_stall), 1); chk("t1_c0_mstart", 64'(mu.mult_start), 0);
        cyc();
        @(negedge clk); chk("t1_c1_stall", 64'(mdu_stall), 1); chk("t1_c1_mstart", 64'(mu.mult_start), 1);
        cyc();
        @(negedge clk); chk("t1_c2_stall", 64'(mdu_stall), 1); chk("t1_c2_mstart", 64'(mu.mult_start), 0);
        chk("t1_c2_we", 64'(hilo_we), 0);
        cyc();
        @(negedge clk); chk("t1_c3_stall", 64'(mdu_stall), 0); chk("t1_c3_we", 64'(hilo_we), 1);
        cyc(); idle_ex();
        @(negedge clk); chk("t1_c4_stall", 64'(mdu_stall), 0); chk("t1_c4_we", 64'(hilo_we), 0);

        // DIVU 100/7, divider answers on cycle 33
        div_lat = 31;
        we0 = n_we;
        cyc();
        drive_op(1, 0, 32'd100, 32'd7);
        exp_q.push_back({32'd2, 32'd14});
        @(negedge clk); chk("t2_c0_dstart", 64'(mu.div_start), 0);
        c = 0; start_ok = 1;
        while (c < 100) begin
            cyc(); c++;
            @(negedge clk);
            if (mu.div_ready) break;
            if (!mu.div_start) start_ok = 0;
        end
        chk("t2_ready_cycle", 64'(c), 33);
        chk("t2_dstart_held", 64'(start_ok), 1);
        chk("t2_dstart_drop", 64'(mu.div_start), 0);
        chk("t2_we_early", 64'(hilo_we), 0);
        cyc();
        @(negedge clk); chk("t2_we", 64'(hilo_we), 1);
        cyc(); idle_ex();
        @(negedge clk); chk("t2_we_after", 64'(hilo_we), 0);
        chk("t2_we_count", 64'(n_we - we0), 1);

        // DIV flushed on cycle 10, stray div_ready on cycle 12
        div_lat = 60;
        we0 = n_we;
        cyc();
        drive_op(1, 1, $urandom, 32'd3);
        exp_q.push_back(64'd0);
        repeat (9) cyc();
        cyc(); ex_flush = 1; void'(exp_q.pop_back());
        @(negedge clk); chk("t3_c10_we", 64'(hilo_we), 0);
        cyc(); idle_ex();
        @(negedge clk);
        chk("t3_c11_annul", 64'(mu.div_annul), 1);
        chk("t3_c11_stall", 64'(mdu_stall), 0);
        chk("t3_c11_dstart", 64'(mu.div_start), 0);
        force_ready = 1;
        cyc();
        @(negedge clk);
        chk("t3_c12_we", 64'(hilo_we), 0);
        chk("t3_c12_annul", 64'(mu.div_annul), 0);
        cyc();
        @(negedge clk); chk("t3_c13_we", 64'(hilo_we), 0);
        chk("t3_we_count", 64'(n_we - we0), 0);

        // MULT completing under a 3-cycle ex_hold
        we0 = n_we;
        a = $urandom; b = $urandom;
        e = ref_res(0, 1, a, b);
        cyc();
        drive_op(0, 1, a, b);
        exp_q.push_back(e);
        repeat (2) cyc();
        for (int k = 3; k <= 5; k++) begin
            cyc(); ex_hold = 1;
            @(negedge clk);
            chk("t4_hold_we", 64'(hilo_we), 0);
            chk("t4_hold_wdata", hilo_wdata, e);
        end
        cyc(); ex_hold = 0;
        @(negedge clk); chk("t4_release_we", 64'(hilo_we), 1); chk("t4_release_wdata", hilo_wdata, e);
        cyc(); idle_ex();
        @(negedge clk); chk("t4_we_count", 64'(n_we - we0), 1);

        // Asynchronous reset in the middle of a divide
        cyc();
        drive_op(1, 0, 32'd1000, 32'd9);
        exp_q.push_back(64'd0);
        repeat (5) cyc();
        #2 rst = 1;
        void'(exp_q.pop_back());
        #1 chk_all_zero("t5_async");
        idle_ex();
        repeat (2) cyc();
        rst = 0;
        div_lat = 4;
        run_op(1, 0, 32'd1000, 32'd9, -1, 0);
        cyc(); idle_ex();

        // Divide by zero
`ifdef MULDIV_DIVZERO_BYPASS_EN
        we0 = n_we;
        cyc();
        drive_op(1, 0, 32'd5, 32'd0);
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        @(negedge clk); chk("t6_c0_stall", 64'(mdu_stall), 1); chk("t6_c0_dstart", 64'(mu.div_start), 0);
        cyc();
        @(negedge clk); chk("t6_c1_we", 64'(hilo_we), 1); chk("t6_c1_dstart", 64'(mu.div_start), 0);
        chk("t6_c1_stall", 64'(mdu_stall), 0);
        cyc(); idle_ex();
        @(negedge clk); chk("t6_we_count", 64'(n_we - we0), 1);
`else
        run_op(1, 0, 32'd5, 32'd0, -1, 0);
        cyc(); idle_ex();
`endif

        // Randomized traffic with holds, flushes and back-to-back ops
        for (int i = 0; i < 60; i++) begin
            d = 1'($urandom); s = 1'($urandom);
            a = ($urandom_range(3) == 0) ? 32'($urandom_range(200)) : $urandom;
            b = ($urandom_range(7) == 0) ? 32'd0 : (($urandom_range(3) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            div_lat = $urandom_range(0, 20);
            fa = ($urandom_range(4) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_op(d, s, a, b, fa, 30);
            if ($urandom_range(2) == 0) begin cyc(); idle_ex(); end
        end
        cyc(); idle_ex();
        repeat (5) cyc();
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
